// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key schedule with a buffered round-key read port
module aes_key_expander #(
  parameter int MAX_NK    = 8,
  parameter int KEY_W     = 32 * MAX_NK,
  parameter int MAX_WORDS = 4 * (MAX_NK + 7)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] key_in,
  input  logic [1:0]       key_mode,
  output logic             busy,
  output logic             done,
  output logic [3:0]       num_rounds,
  output logic             err,
  input  logic             rk_rd_en,
  input  logic [3:0]       rk_rd_round,
  output logic [127:0]     rk_rd_data,
  output logic             rk_rd_valid
);
  localparam logic [1:0] IDLE = 2'd0, EXPAND = 2'd1, READY = 2'd2;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic [31:0] w [MAX_WORDS];
  logic [1:0]  state;
  logic [5:0]  i;
  logic [7:0]  rcon;
  logic [2:0]  phase;
  logic [3:0]  nk, nr, nk_sel, nr_sel;
  logic [31:0] prev, t;
  logic [5:0]  rd_base;
  logic        accept, legal, rd_ok, last;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    for (int b = 0; b < 4; b++) sub_word[8*b +: 8] = SBOX[11'd2047 - {x[8*b +: 8], 3'b000} -: 8];
  endfunction

  assign key_ready = state != EXPAND;
  assign busy      = state == EXPAND;
  assign done      = state == READY;
  assign nk_sel    = key_mode == 2'b00 ? 4'd4 : key_mode == 2'b01 ? 4'd6 : 4'd8;
  assign nr_sel    = nk_sel + 4'd6;
  assign legal     = key_mode != 2'b11 && int'(nk_sel) <= MAX_NK;
  assign accept    = key_valid && key_ready;
  assign rd_ok     = rk_rd_en && state == READY && rk_rd_round <= num_rounds;
  assign rd_base   = {rk_rd_round, 2'b00};
  assign last      = i == {nr, 2'b11};

  // next schedule word's mixing term t, derived from w[i-1]
  always_comb begin
    prev = w[i - 6'd1];
    t = phase == 3'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0}
      : (nk == 4'd8 && phase == 3'd4) ? sub_word(prev) : prev;
  end

  // word buffer: key load on acceptance, one derived word per EXPAND edge; never cleared
  always_ff @(posedge clk) begin
    if (accept && legal) begin
      for (int j = 0; j < MAX_NK; j++) if (j < int'(nk_sel)) w[j] <= key_in[KEY_W-1-32*j -: 32];
    end else if (state == EXPAND) w[i] <= w[i - {2'b00, nk}] ^ t;
  end

  // FSM, schedule counters and read port; a read on an accept edge still sees the old buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      i           <= '0;
      rcon        <= 8'h01;
      phase       <= '0;
      nk          <= 4'd4;
      nr          <= 4'd10;
      num_rounds  <= '0;
      err         <= 1'b0;
      rk_rd_valid <= 1'b0;
      rk_rd_data  <= '0;
    end else begin
      err         <= (accept && !legal) || (rk_rd_en && !rd_ok);
      rk_rd_valid <= rd_ok;
      if (rd_ok) rk_rd_data <= {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
      if (accept && legal) begin
        state <= EXPAND;
        i     <= {2'b00, nk_sel};
        rcon  <= 8'h01;
        phase <= '0;
        nk    <= nk_sel;
        nr    <= nr_sel;
      end else if (state == EXPAND) begin
        i     <= i + 6'd1;
        phase <= {1'b0, phase} == nk - 4'd1 ? 3'd0 : phase + 3'd1;
        if (phase == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        if (last) begin
          state      <= READY;
          num_rounds <= nr;
        end
      end
    end
  end
endmodule
